// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one combinational 32-bit shifter among NREQ requesters
// Ports:
//   i_clk, i_rst_n           clock (rising edge) and asynchronous active-low reset
//   i_req_valid/o_req_ready  per-requester valid/ready handshake, at most one ready bit set
//   i_req_a/i_req_b/i_req_op packed per-requester operand, shift amount and op (00 SLL, 01 SRL, 11 SRA, 10 SRL)
//   o_rsp_valid/i_rsp_ready  registered response handshake
//   o_rsp_data/o_rsp_id      shift result and the index of the requester that issued it
module shift_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NREQ-1:0]     i_req_valid,
    output logic [NREQ-1:0]     o_req_ready,
    input  logic [32*NREQ-1:0]  i_req_a,
    input  logic [5*NREQ-1:0]   i_req_b,
    input  logic [2*NREQ-1:0]   i_req_op,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [31:0]         o_rsp_data,
    output logic [ID_W-1:0]     o_rsp_id
);
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   sel;
    logic              found;
    logic              can_accept;
    logic              xfer;
    logic [31:0]       a_sel;
    logic [4:0]        b_sel;
    logic [1:0]        op_sel;
    logic signed [31:0] sra;
    logic [31:0]       result;

    assign can_accept = !o_rsp_valid || i_rsp_ready;
    assign xfer       = |o_req_ready;

    // Search starts one past the last-served requester and wraps around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && i_req_valid[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                sel   = ID_W'((int'(ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        o_req_ready      = '0;
        o_req_ready[sel] = found && can_accept;
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (ID_W'(k) == sel) begin
                a_sel  = i_req_a[32*k +: 32];
                b_sel  = i_req_b[5*k +: 5];
                op_sel = i_req_op[2*k +: 2];
            end
        end
    end

    // Kept as its own signed net so the arithmetic shift is not turned logical by ternary context.
    assign sra    = $signed(a_sel) >>> b_sel;
    assign result = op_sel == 2'b00 ? a_sel << b_sel :
                    op_sel == 2'b11 ? unsigned'(sra) : a_sel >> b_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= '0;
            ptr         <= ID_W'(NREQ - 1);
        end else if (xfer) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= result;
            o_rsp_id    <= sel;
            ptr         <= sel;
        end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end
endmodule
